l0_cache_miss_handler: RTL and testbench

Sequential miss path for the L0 data cache, directly downstream of the cache hit detector: consumes the per-load hit decision and, on a miss, stalls the pipeline, issues a single-word read to data memory, returns the word to the load unit, and refills the direct-mapped L0 entry (tag, data, all valid bits). MMIO loads are serviced through the same path but never fill the cache. Free-running hit/miss counters support performance monitoring.

---
 rtl/l0_cache_miss_handler.sv | 110 +++++++++++
 tb/tb_l0_cache_miss_handler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/l0_cache_miss_handler.sv
// L0 data cache miss path: stalls on a miss, fetches one word from data memory,
// returns it to the load unit and refills the direct-mapped entry (MMIO never fills).
module l0_cache_miss_handler #(
    parameter int              XLEN            = 32,
    parameter int              CacheTagWidth   = 7,
    parameter int              CacheIndexWidth = 7,
    parameter logic [XLEN-1:0] MMIO_ADDR       = 32'h4000_0000
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_load_valid,
    input  logic                       i_cache_hit_on_load,
    input  logic [XLEN-1:0]            i_address,
    input  logic                       i_flush,
    output logic                       o_stall,
    output logic                       o_mem_req_valid,
    input  logic                       i_mem_req_ready,
    output logic [XLEN-1:0]            o_mem_req_addr,
    input  logic                       i_mem_rsp_valid,
    input  logic [XLEN-1:0]            i_mem_rsp_data,
    output logic                       o_load_data_valid,
    output logic [XLEN-1:0]            o_load_data,
    output logic                       o_cache_wr_en,
    output logic [CacheIndexWidth-1:0] o_cache_wr_index,
    output logic [CacheTagWidth-1:0]   o_cache_wr_tag,
    output logic [XLEN-1:0]            o_cache_wr_data,
    output logic [XLEN/8-1:0]          o_cache_wr_valid_bits,
    output logic [31:0]                o_hit_count,
    output logic [31:0]                o_miss_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam int TagLo = CacheIndexWidth + 2;
    localparam int TagHi = CacheIndexWidth + CacheTagWidth + 1;

    logic [1:0]      state;
    logic [XLEN-1:2] addr_q;
    logic            mmio_q;
    logic            drop_q;
    logic [31:0]     hit_cnt;
    logic [31:0]     miss_cnt;

    logic miss;
    logic hit;
    logic rsp_take;

    always_comb begin
        miss     = (state == S_IDLE) && i_load_valid && !i_cache_hit_on_load && !i_flush;
        hit      = (state == S_IDLE) && i_load_valid && i_cache_hit_on_load;
        rsp_take = (state == S_WAIT) && i_mem_rsp_valid;

        o_stall         = miss || (state == S_REQ) || ((state == S_WAIT) && !i_mem_rsp_valid);
        // A flush in REQ withdraws the request in the same cycle so memory never sees it.
        o_mem_req_valid = (state == S_REQ) && !i_flush;
        o_mem_req_addr  = {addr_q, 2'b00};

        o_load_data_valid = rsp_take && !drop_q && !i_flush;
        o_load_data       = rsp_take ? i_mem_rsp_data : '0;

        // The fill happens even for a dropped load: the returned word is still valid data.
        o_cache_wr_en         = rsp_take && !mmio_q;
        o_cache_wr_index      = addr_q[CacheIndexWidth+1:2];
        o_cache_wr_tag        = addr_q[TagHi:TagLo];
        o_cache_wr_data       = o_cache_wr_en ? i_mem_rsp_data : '0;
        o_cache_wr_valid_bits = {(XLEN/8){o_cache_wr_en}};

        o_hit_count  = hit_cnt;
        o_miss_count = miss_cnt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            mmio_q   <= 1'b0;
            drop_q   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hit) hit_cnt <= hit_cnt + 32'd1;
                    if (miss) begin
                        addr_q <= i_address[XLEN-1:2];
                        mmio_q <= (i_address >= MMIO_ADDR);
                        drop_q <= 1'b0;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_flush)              state <= S_IDLE;
                    else if (i_mem_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_mem_rsp_valid) begin
                        miss_cnt <= miss_cnt + 32'd1;
                        state    <= S_IDLE;
                    end else if (i_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l0_cache_miss_handler.sv
// Randomized + directed bench for l0_cache_miss_handler against a transaction-level model.
module tb_l0_cache_miss_handler;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        cache_hit;
    logic [31:0] address;
    logic        flush;
    logic        stall;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        wr_en;
    logic [6:0]  wr_index;
    logic [6:0]  wr_tag;
    logic [31:0] wr_data;
    logic [3:0]  wr_vbits;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    l0_cache_miss_handler dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_load_valid          (load_valid),
        .i_cache_hit_on_load   (cache_hit),
        .i_address             (address),
        .i_flush               (flush),
        .o_stall               (stall),
        .o_mem_req_valid       (req_valid),
        .i_mem_req_ready       (req_ready),
        .o_mem_req_addr        (req_addr),
        .i_mem_rsp_valid       (rsp_valid),
        .i_mem_rsp_data        (rsp_data),
        .o_load_data_valid     (ld_valid),
        .o_load_data           (ld_data),
        .o_cache_wr_en         (wr_en),
        .o_cache_wr_index      (wr_index),
        .o_cache_wr_tag        (wr_tag),
        .o_cache_wr_data       (wr_data),
        .o_cache_wr_valid_bits (wr_vbits),
        .o_hit_count           (hit_count),
        .o_miss_count          (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding miss transaction, described by flags.
    bit          m_busy;     // a miss is outstanding
    bit          m_acc;      // memory has accepted its request
    bit          m_drop;     // load was flushed while waiting
    logic [31:0] m_addr;
    int unsigned m_hits;
    int unsigned m_misses;
    int          lat_left;

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_drop = 0; m_addr = 0;
        m_hits = 0; m_misses = 0; lat_left = 0;
    endtask

    task automatic check_outputs(input bit lv, input bit h, input logic [31:0] a,
                                 input bit fl, input bit rv, input logic [31:0] rd);
        bit new_miss, take, exp_ld, exp_wr, is_mmio;
        new_miss = !m_busy && lv && !h && !fl;
        take     = m_busy && m_acc && rv;
        exp_ld   = take && !m_drop && !fl;
        is_mmio  = (m_addr >= 32'h4000_0000);
        exp_wr   = take && !is_mmio;
        chk("stall", 32'(stall), 32'(new_miss || (m_busy && !m_acc) || (m_busy && m_acc && !rv)));
        chk("req_valid", 32'(req_valid), 32'(m_busy && !m_acc && !fl));
        if (m_busy && !m_acc && !fl) chk("req_addr", req_addr, (m_addr / 4) * 4);
        chk("ld_valid", 32'(ld_valid), 32'(exp_ld));
        if (exp_ld) chk("ld_data", ld_data, rd);
        chk("wr_en", 32'(wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_index", 32'(wr_index), (m_addr / 4) % 128);
            chk("wr_tag", 32'(wr_tag), (m_addr / 512) % 128);
            chk("wr_data", wr_data, rd);
            chk("wr_vbits", 32'(wr_vbits), 32'hF);
        end
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
    endtask

    task automatic model_update(input bit lv, input bit h, input logic [31:0] a,
                                input bit fl, input bit rdy, input bit rv);
        if (!m_busy) begin
            if (lv && h) m_hits++;
            if (lv && !h && !fl) begin
                m_busy = 1; m_acc = 0; m_drop = 0; m_addr = a;
            end
        end else if (!m_acc) begin
            if (fl) m_busy = 0;
            else if (rdy) begin
                m_acc = 1;
                lat_left = $urandom_range(0, 3);
            end
        end else begin
            if (rv) begin
                m_busy = 0; m_acc = 0; m_misses++;
            end else if (fl) m_drop = 1;
        end
    endtask

    // Called at posedge+1: drive, check mid-cycle, advance model, move to next posedge+1.
    task automatic step(input bit lv, input bit h, input logic [31:0] a, input bit fl,
                        input bit rdy, input bit rv, input logic [31:0] rd);
        load_valid = lv; cache_hit = h; address = a; flush = fl;
        req_ready = rdy; rsp_valid = rv; rsp_data = rd;
        #4;
        check_outputs(lv, h, a, fl, rv, rd);
        model_update(lv, h, a, fl, rdy, rv);
        @(posedge clk); #1;
    endtask

    initial begin
        bit lv, h, fl, rdy, rv;
        logic [31:0] a;
        model_reset();
        rst_n = 1'b0;
        load_valid = 0; cache_hit = 0; address = 0; flush = 0;
        req_ready = 0; rsp_valid = 0; rsp_data = 0;
        #12;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req_valid", 32'(req_valid), 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_wr_tag_idx", {18'd0, wr_tag, wr_index}, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_counts", hit_count | miss_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Hit: no stall, hit count 0 -> 1
        step(1, 1, 32'h0000_0100, 0, 1, 0, 0);
        chk("dir_hit_count", hit_count, 1);

        // Cacheable miss, 1-cycle memory
        step(1, 0, 32'h0000_1234, 0, 1, 0, 0);
        step(1, 0, 32'h0000_1234, 0, 1, 0, 0);
        step(1, 0, 32'h0000_1234, 0, 1, 1, 32'hDEAD_BEEF);
        chk("dir_miss_count", miss_count, 1);

        // MMIO miss: returned but not filled
        step(1, 0, 32'h4000_0008, 0, 1, 0, 0);
        step(1, 0, 32'h4000_0008, 0, 1, 0, 0);
        step(1, 0, 32'h4000_0008, 0, 1, 1, 32'h1234_5678);
        // Last cacheable address below the MMIO window
        step(1, 0, 32'h3FFF_FFFC, 0, 1, 0, 0);
        step(1, 0, 32'h3FFF_FFFC, 0, 1, 0, 0);
        step(1, 0, 32'h3FFF_FFFC, 0, 1, 1, 32'hCAFE_F00D);

        // Backpressure: ready low 3 cycles, response 4 cycles after accept
        step(1, 0, 32'h0000_2468, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0000_2468, 0, 0, 0, 0);
        step(1, 0, 32'h0000_2468, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0000_2468, 0, 0, 0, 0);
        step(1, 0, 32'h0000_2468, 0, 0, 1, 32'hA5A5_5A5A);

        // Flush in REQ, then flush in WAIT, then flush together with response
        step(1, 0, 32'h0000_0ABC, 0, 0, 0, 0);
        step(1, 0, 32'h0000_0ABC, 1, 1, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 0);
        step(1, 0, 32'h0000_0ABC, 0, 1, 0, 0);
        step(1, 0, 32'h0000_0ABC, 0, 1, 0, 0);
        step(1, 0, 32'h0000_0ABC, 1, 0, 0, 0);
        step(1, 0, 32'h0000_0ABC, 0, 0, 1, 32'h0BAD_CAFE);
        step(1, 0, 32'h0000_3CC0, 0, 1, 0, 0);
        step(1, 0, 32'h0000_3CC0, 0, 1, 0, 0);
        step(1, 0, 32'h0000_3CC0, 1, 0, 1, 32'h7777_1111);

        // Randomized traffic, including stray responses outside WAIT
        for (int c = 0; c < 3000; c++) begin
            lv  = ($urandom % 4) != 0;
            h   = ($urandom % 2) != 0;
            fl  = ($urandom % 10) == 0;
            rdy = ($urandom % 3) != 0;
            a   = ($urandom % 4 == 0) ? ($urandom | 32'h4000_0000) : ($urandom & 32'h3FFF_FFFF);
            if (m_busy) a = m_addr;
            if (m_busy && m_acc) begin
                rv = (lat_left == 0);
                if (!rv) lat_left--;
            end else rv = ($urandom % 6) == 0;
            step(lv, h, a, fl, rdy, rv, $urandom);
        end

        // Reset asserted in WAIT, then a late response after release
        while (m_busy) step(0, 0, 0, 0, 1, 1, 32'h0);
        step(1, 0, 32'h0000_5550, 0, 1, 0, 0);
        step(1, 0, 32'h0000_5550, 0, 1, 0, 0);
        load_valid = 0; rsp_valid = 0; flush = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #2;
        chk("midrst_stall", 32'(stall), 0);
        chk("midrst_req_valid", 32'(req_valid), 0);
        chk("midrst_counts", hit_count | miss_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 1, 32'hFEED_FACE);
        step(0, 0, 0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
